fifo_rd_serializer: RTL and testbench

FIFO_RD_SERIALIZER -- requirements
Module: fifo_rd_serializer

---
 rtl/fifo_rd_serializer.sv | 138 +++++++++++++
 tb/tb_fifo_rd_serializer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_serializer.sv
// rtl/fifo_rd_serializer.sv - pops words from a FIFO and sends them as serial frames (start, data LSB first, optional parity, stop)
module fifo_rd_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  r_inc,
  input  logic [5:0]            prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [5:0]            pre_q;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic [5:0]            bit_cnt;
  logic [IDX_W-1:0]      idx;
  logic [5:0]            pre_eff;
  logic                  bit_end;

  assign pre_eff = (prescale == 6'd0) ? 6'd1 : prescale;
  assign bit_end = (bit_cnt == 6'd0);

  // Outputs are registered alongside the state so they change only on clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_q   <= '0;
      pre_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      bit_cnt   <= '0;
      idx       <= '0;
      r_inc     <= 1'b0;
      tx_out    <= 1'b1;
      busy      <= 1'b0;
    end else begin
      r_inc <= 1'b0;
      case (state)
        IDLE: begin
          tx_out <= 1'b1;
          busy   <= 1'b0;
          if (!empty) begin
            state <= LOAD;
            r_inc <= 1'b1;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          shift_q   <= rd_data;
          pre_q     <= pre_eff;
          par_en_q  <= par_en;
          par_bit_q <= (^rd_data) ^ par_typ;
          bit_cnt   <= pre_eff - 6'd1;
          state     <= START;
          tx_out    <= 1'b0;
        end
        START: begin
          if (bit_end) begin
            bit_cnt <= pre_q - 6'd1;
            idx     <= '0;
            state   <= DATA;
            tx_out  <= shift_q[0];
          end else begin
            bit_cnt <= bit_cnt - 6'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= pre_q - 6'd1;
            if (idx == LAST_IDX) begin
              if (par_en_q) begin
                state  <= PARITY;
                tx_out <= par_bit_q;
              end else begin
                state  <= STOP;
                tx_out <= 1'b1;
              end
            end else begin
              idx     <= idx + IDX_W'(1);
              shift_q <= shift_q >> 1;
              tx_out  <= shift_q[1];
            end
          end else begin
            bit_cnt <= bit_cnt - 6'd1;
          end
        end
        PARITY: begin
          if (bit_end) begin
            bit_cnt <= pre_q - 6'd1;
            state   <= STOP;
            tx_out  <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt - 6'd1;
          end
        end
        STOP: begin
          // Only here is EMPTY sampled for the next word; a refill chains frames with one LOAD cycle.
          if (bit_end) begin
            if (!empty) begin
              state <= LOAD;
              r_inc <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt - 6'd1;
          end
        end
        default: begin
          state  <= IDLE;
          tx_out <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// tb/tb_fifo_rd_serializer.sv - randomized self-checking bench for fifo_rd_serializer against a frame-level model
module tb_fifo_rd_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         empty;
  logic [W-1:0] rd_data;
  logic         r_inc;
  logic [5:0]   prescale = 6'd1;
  logic         par_en = 1'b0;
  logic         par_typ = 1'b0;
  logic         tx_out;
  logic         busy;

  always #5 clk = ~clk;

  // FIFO model feeding the DUT read port
  logic [W-1:0] mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_viol = 0;

  assign empty   = (wr_ptr == rd_ptr);
  assign rd_data = mem[rd_ptr[3:0]];

  always @(posedge clk) begin
    if (r_inc) begin
      if (wr_ptr == rd_ptr) pop_viol <= pop_viol + 1;
      else                  rd_ptr   <= rd_ptr + 1;
    end
  end

  fifo_rd_serializer #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .empty    (empty),
    .rd_data  (rd_data),
    .r_inc    (r_inc),
    .prescale (prescale),
    .par_en   (par_en),
    .par_typ  (par_typ),
    .tx_out   (tx_out),
    .busy     (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  logic [W-1:0] words [$];
  bit o_tx [$], o_busy [$], o_rinc [$];
  bit e_tx [$], e_busy [$], e_rinc [$];

  // Expected per-cycle (tx, busy, r_inc) from the frame rules, starting the cycle after the first pop decision.
  task automatic build_expected();
    int p, nbits, b, ones;
    bit par;
    logic [W-1:0] w;
    e_tx.delete(); e_busy.delete(); e_rinc.delete();
    p = (prescale == 0) ? 1 : int'(prescale);
    nbits = W + 2 + (par_en ? 1 : 0);
    foreach (words[j]) begin
      w = words[j];
      ones = 0;
      for (int k = 0; k < W; k++) ones += int'(w[k]);
      par = bit'(ones % 2) ^ par_typ;
      e_tx.push_back(1); e_busy.push_back(1); e_rinc.push_back(1);
      for (int t = 0; t < p * nbits; t++) begin
        b = t / p;
        if (b == 0)                        e_tx.push_back(0);
        else if (b <= W)                   e_tx.push_back(w[b-1]);
        else if (par_en && b == W + 1)     e_tx.push_back(par);
        else                               e_tx.push_back(1);
        e_busy.push_back(1); e_rinc.push_back(0);
      end
    end
    e_tx.push_back(1); e_busy.push_back(0); e_rinc.push_back(0);
  endtask

  task automatic push_words();
    foreach (words[j]) begin
      mem[wr_ptr[3:0]] = words[j];
      wr_ptr++;
    end
  endtask

  task automatic capture(input string tag, input int budget);
    bit seen = 0;
    bit done = 0;
    o_tx.delete(); o_busy.delete(); o_rinc.delete();
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      o_tx.push_back(tx_out); o_busy.push_back(busy); o_rinc.push_back(r_inc);
      if (busy) seen = 1;
      if (seen && !busy) done = 1;
    end
    if (!done) check({tag, "_capture_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic compare(input string tag);
    int first_bad = -1;
    int n = (o_tx.size() > e_tx.size()) ? o_tx.size() : e_tx.size();
    for (int i = 0; i < n; i++) begin
      if (i >= o_tx.size() || i >= e_tx.size() ||
          {o_tx[i], o_busy[i], o_rinc[i]} != {e_tx[i], e_busy[i], e_rinc[i]}) begin
        first_bad = i;
        break;
      end
    end
    check({tag, "_first_bad_cycle"}, first_bad, -1);
  endtask

  task automatic run_case(input string tag);
    build_expected();
    push_words();
    capture(tag, 600);
    compare(tag);
  endtask

  function automatic int count_q(input bit q [$]);
    int c = 0;
    foreach (q[i]) c += int'(q[i]);
    return c;
  endfunction

  function automatic logic [31:0] pack_tx(input int first, input int len);
    logic [31:0] v = '0;
    for (int i = first; i < first + len; i++) v = {v[30:0], (i < o_tx.size()) ? o_tx[i] : 1'bx};
    return v;
  endfunction

  logic [31:0] p1_trace;
  int cnt_a, cnt_b;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_tx_out", tx_out, 1);
    check("reset_busy", busy, 0);
    check("reset_r_inc", r_inc, 0);
    rst_n = 1'b1;

    cnt_a = 0; cnt_b = 0;
    repeat (100) begin
      @(negedge clk);
      if (r_inc !== 1'b0) cnt_a++;
      if (tx_out !== 1'b1) cnt_b++;
    end
    check("empty_r_inc_cycles", cnt_a, 0);
    check("empty_tx_low_cycles", cnt_b, 0);

    prescale = 6'd1; par_en = 0; par_typ = 0;
    words = '{8'hA5};
    run_case("a5_p1");
    check("a5_r_inc_count", count_q(o_rinc), 1);
    check("a5_busy_cycles", count_q(o_busy), 11);
    check("a5_tx_bits", pack_tx(1, 10), 32'b0101001011);
    p1_trace = pack_tx(0, 13);

    prescale = 6'd0;
    run_case("a5_p0");
    check("p0_equals_p1", pack_tx(0, 13), p1_trace);

    prescale = 6'd1; par_en = 1; par_typ = 0;
    words = '{8'hA5};
    run_case("par_even_a5");
    check("par_even_a5_bit", o_tx.size() > 10 ? o_tx[10] : 1'bx, 0);
    par_typ = 1;
    words = '{8'h07};
    run_case("par_odd_07");
    check("par_odd_07_bit", o_tx.size() > 10 ? o_tx[10] : 1'bx, 0);

    prescale = 6'd4; par_en = 0; par_typ = 0;
    words = '{8'h01};
    run_case("p4_01");
    check("p4_frame_cycles", count_q(o_busy) - 1, 40);
    check("p4_start_bit", pack_tx(1, 4), 32'b0000);
    check("p4_data0_bit", pack_tx(5, 4), 32'b1111);

    prescale = 6'd1;
    words = '{8'h11, 8'h22, 8'h33};
    run_case("b2b");
    check("b2b_r_inc_count", count_q(o_rinc), 3);
    check("b2b_busy_cycles", count_q(o_busy), 33);
    check("b2b_back_to_idle", busy, 0);

    for (int it = 0; it < 8; it++) begin
      int n;
      prescale = 6'($urandom_range(0, 5));
      par_en   = 1'($urandom_range(0, 1));
      par_typ  = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 3);
      words.delete();
      for (int j = 0; j < n; j++) words.push_back(W'($urandom));
      run_case($sformatf("rand%0d", it));
      check($sformatf("rand%0d_r_inc_count", it), count_q(o_rinc), n);
    end

    // Abort a frame during data bit 3 (0x52 sends 0 there)
    prescale = 6'd1; par_en = 0; par_typ = 0;
    words = '{8'h52};
    push_words();
    repeat (6) @(negedge clk);
    check("pre_abort_tx_bit3", tx_out, 0);
    check("pre_abort_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_tx_out", tx_out, 1);
    check("abort_busy", busy, 0);
    check("abort_r_inc", r_inc, 0);
    words = '{8'hC3};
    push_words();
    cnt_a = 0;
    repeat (5) begin
      @(negedge clk);
      if (r_inc !== 1'b0) cnt_a++;
    end
    check("in_reset_r_inc_cycles", cnt_a, 0);
    rst_n = 1'b1;
    build_expected();
    capture("after_reset", 600);
    compare("after_reset");

    check("r_inc_while_empty", pop_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
